// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier issue wrapper: operand width defaults,
// controller state encoding and the busy-acknowledge window.
package mult_pkg;

  localparam int MBITS_DEF = 12;
  localparam int NBITS_DEF = 8;

  // Cycles ARM waits for mult to raise busy before the op is abandoned.
  localparam int ARM_LIMIT = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ARM,
    BUSY,
    DONE
  } state_t;

endpackage

// File: rtl/mult_op_fifo.sv
// Small operand FIFO with synchronous write/pop; the head is visible
// combinationally so a pop and the operand load happen on the same edge.
module mult_op_fifo
  import mult_pkg::*;
#(
  parameter int W     = MBITS_DEF + NBITS_DEF,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW:0]   count_reg;
  logic          wr_ok;
  logic          rd_ok;

  assign full    = (count_reg == (PW + 1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  assign rd_data = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_ok) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (rd_ok) rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count_reg <= count_reg + (PW + 1)'(1);
        2'b01:   count_reg <= count_reg - (PW + 1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/mult_issue_ctrl.sv
// Issue controller for the sequential signed multiplier: queues operand pairs,
// pulses start, times the busy window and presents the product or a timeout.
module mult_issue_ctrl
  import mult_pkg::*;
#(
  parameter int MBITS = MBITS_DEF,
  parameter int NBITS = NBITS_DEF,
  parameter int DEPTH = 4,
  parameter int TMO   = 64,
  parameter int CW    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [MBITS-1:0]       in_mpd,
  input  logic [NBITS-1:0]       in_mpr,
  output logic [MBITS-1:0]       mult_mpd,
  output logic [NBITS-1:0]       mult_mpr,
  output logic                   mult_start,
  input  logic                   mult_busy,
  input  logic [MBITS+NBITS-1:0] mult_prod,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [MBITS+NBITS-1:0] out_prod,
  output logic [CW-1:0]          out_cycles,
  output logic                   out_tmo
);

  localparam int DW = MBITS + NBITS;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next, cnt_inc;
  logic [MBITS-1:0] mpd_reg, mpd_next;
  logic [NBITS-1:0] mpr_reg, mpr_next;
  logic            valid_reg, valid_next;
  logic [DW-1:0]   prod_reg, prod_next;
  logic [CW-1:0]   cycles_reg, cycles_next;
  logic            tmo_reg, tmo_next;
  logic            ready_en_reg;

  logic            fifo_rd;
  logic [DW-1:0]   fifo_head;
  logic            fifo_full;
  logic            fifo_empty;

  mult_op_fifo #(.W(DW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (in_valid && in_ready),
    .wr_data ({in_mpd, in_mpr}),
    .rd_en   (fifo_rd),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Held low through reset and for the first edge after release.
  assign in_ready   = ready_en_reg && !fifo_full;
  assign mult_start = (state_reg == START);
  assign mult_mpd   = mpd_reg;
  assign mult_mpr   = mpr_reg;
  assign out_valid  = valid_reg;
  assign out_prod   = prod_reg;
  assign out_cycles = cycles_reg;
  assign out_tmo    = tmo_reg;
  assign cnt_inc    = (cnt_reg == {CW{1'b1}}) ? cnt_reg : cnt_reg + CW'(1);

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    mpd_next    = mpd_reg;
    mpr_next    = mpr_reg;
    valid_next  = valid_reg;
    prod_next   = prod_reg;
    cycles_next = cycles_reg;
    tmo_next    = tmo_reg;
    fifo_rd     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty && !valid_reg) begin
          fifo_rd    = 1'b1;
          mpd_next   = fifo_head[DW-1:NBITS];
          mpr_next   = fifo_head[NBITS-1:0];
          state_next = START;
        end
      end
      START: begin
        cnt_next   = '0;
        state_next = ARM;
      end
      ARM: begin
        if (mult_busy) begin
          // The busy cycle seen here is the first one of the op.
          cnt_next   = CW'(1);
          state_next = BUSY;
        end else if (cnt_reg == CW'(ARM_LIMIT - 1)) begin
          prod_next   = '0;
          cycles_next = '0;
          tmo_next    = 1'b1;
          valid_next  = 1'b1;
          state_next  = DONE;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      BUSY: begin
        if (!mult_busy) begin
          prod_next   = mult_prod;
          cycles_next = cnt_reg;
          tmo_next    = 1'b0;
          valid_next  = 1'b1;
          state_next  = DONE;
        end else if (cnt_reg == CW'(TMO)) begin
          prod_next   = '0;
          cycles_next = cnt_reg;
          tmo_next    = 1'b1;
          valid_next  = 1'b1;
          state_next  = DONE;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      DONE: begin
        if (out_ready) begin
          valid_next = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      mpd_reg      <= '0;
      mpr_reg      <= '0;
      valid_reg    <= 1'b0;
      prod_reg     <= '0;
      cycles_reg   <= '0;
      tmo_reg      <= 1'b0;
      ready_en_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      mpd_reg      <= mpd_next;
      mpr_reg      <= mpr_next;
      valid_reg    <= valid_next;
      prod_reg     <= prod_next;
      cycles_reg   <= cycles_next;
      tmo_reg      <= tmo_next;
      ready_en_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Directed bench for mult_issue_ctrl with a behavioural stand-in for mult
// whose busy length and failure mode are set per test.
module tb_mult_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_mpd;
  logic [7:0]  in_mpr;
  logic [11:0] mult_mpd;
  logic [7:0]  mult_mpr;
  logic        mult_start;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] out_prod;
  logic [7:0]  out_cycles;
  logic        out_tmo;

  int tests  = 0;
  int errors = 0;

  // Stand-in multiplier: 0 = normal, 1 = busy stuck high, 2 = never busy.
  logic        busy_m = 1'b0;
  logic [19:0] prod_m = '0;
  int          left_m = 0;
  int          blen   = 4;
  int          mode   = 0;

  always #5 clk = ~clk;

  mult_issue_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mpd     (in_mpd),
    .in_mpr     (in_mpr),
    .mult_mpd   (mult_mpd),
    .mult_mpr   (mult_mpr),
    .mult_start (mult_start),
    .mult_busy  (busy_m),
    .mult_prod  (prod_m),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_prod   (out_prod),
    .out_cycles (out_cycles),
    .out_tmo    (out_tmo)
  );

  function automatic logic [19:0] smul(input logic [11:0] a, input logic [7:0] b);
    logic signed [19:0] sa;
    logic signed [19:0] sb;
    sa = 20'(signed'(a));
    sb = 20'(signed'(b));
    return 20'(sa * sb);
  endfunction

  always @(posedge clk) begin
    if (mult_start) begin
      if (mode != 2) begin
        busy_m <= 1'b1;
        left_m <= blen - 1;
      end
    end else if (busy_m && mode != 1) begin
      if (left_m == 0) begin
        busy_m <= 1'b0;
        prod_m <= smul(mult_mpd, mult_mpr);
      end else begin
        left_m <= left_m - 1;
      end
    end
  end

  typedef struct {
    logic [11:0] mpd;
    logic [7:0]  mpr;
    int          blen;
    logic [19:0] prod;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    tests++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic push(input logic [11:0] a, input logic [7:0] b);
    int n = 0;
    in_mpd   = a;
    in_mpr   = b;
    in_valid = 1'b1;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) bound_fail("push_ready");
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_start(output int n);
    n = 0;
    while (!mult_start && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) bound_fail("wait_start");
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) bound_fail("wait_valid");
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid_clear", 32'(out_valid), 32'd0);
  endtask

  task automatic run_op(input int i);
    int n;
    blen = vecs[i].blen;
    push(vecs[i].mpd, vecs[i].mpr);
    wait_start(n);
    chk($sformatf("v%0d_start_lat", i), 32'(n), 32'd1);
    wait_valid(n);
    chk($sformatf("v%0d_valid_lat", i), 32'(n), 32'(vecs[i].blen + 2));
    chk($sformatf("v%0d_prod", i), 32'(out_prod), 32'(vecs[i].prod));
    chk($sformatf("v%0d_cycles", i), 32'(out_cycles), 32'(vecs[i].blen));
    chk($sformatf("v%0d_tmo", i), 32'(out_tmo), 32'd0);
    $display("[TB] op %0d: %h x %h -> %h cycles %0d", i, vecs[i].mpd, vecs[i].mpr, out_prod, out_cycles);
    take();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit seen_valid;
    bit seen_start;

    vecs[0] = '{12'h7FF, 8'h7F, 5,  20'h3F781};
    vecs[1] = '{12'h801, 8'h81, 3,  20'h3F781};
    vecs[2] = '{12'h7FF, 8'hFF, 1,  20'hFF801};
    vecs[3] = '{12'h123, 8'h02, 7,  20'h00246};
    vecs[4] = '{12'hFFF, 8'hFF, 2,  20'h00001};
    vecs[5] = '{12'h800, 8'h80, 64, 20'h40000};
    vecs[6] = '{12'h800, 8'h7F, 10, 20'hC0800};
    vecs[7] = '{12'h000, 8'h55, 4,  20'h00000};

    rst = 1'b1; in_valid = 1'b0; in_mpd = '0; in_mpr = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_start", 32'(mult_start), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // First op, then an asynchronous reset while its result is held.
    blen = 5;
    push(vecs[0].mpd, vecs[0].mpr);
    chk("start_not_early", 32'(mult_start), 32'd0);
    wait_start(n);
    chk("first_start_lat", 32'(n), 32'd1);
    wait_valid(n);
    chk("first_prod", 32'(out_prod), 32'h3F781);
    chk("first_cycles", 32'(out_cycles), 32'd5);
    repeat (3) @(negedge clk);
    chk("done_hold_valid", 32'(out_valid), 32'd1);
    chk("done_no_start", 32'(mult_start), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("async_out_valid", 32'(out_valid), 32'd0);
    chk("async_out_prod", 32'(out_prod), 32'd0);
    chk("async_out_cycles", 32'(out_cycles), 32'd0);
    chk("async_mult_mpd", 32'(mult_mpd), 32'd0);
    chk("async_mult_mpr", 32'(mult_mpr), 32'd0);
    chk("async_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("async_release_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 8; i++) run_op(i);

    // FIFO fill behind an unaccepted result.
    blen = 3;
    push(vecs[0].mpd, vecs[0].mpr);
    wait_valid(n);
    for (int k = 1; k <= 4; k++) push(vecs[k].mpd, vecs[k].mpr);
    chk("fifo_full_ready", 32'(in_ready), 32'd0);
    in_mpd = vecs[5].mpd; in_mpr = vecs[5].mpr; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("fifo_full_hold", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    chk("fifo_r0_prod", 32'(out_prod), 32'(vecs[0].prod));
    take();
    push(vecs[5].mpd, vecs[5].mpr);
    for (int k = 1; k <= 5; k++) begin
      wait_valid(n);
      chk($sformatf("fifo_r%0d_prod", k), 32'(out_prod), 32'(vecs[k].prod));
      $display("[TB] fifo result %0d: %h", k, out_prod);
      take();
    end

    // Busy stuck high.
    mode = 1; blen = 3;
    push(vecs[0].mpd, vecs[0].mpr);
    wait_start(n);
    wait_valid(n);
    chk("tmo_busy_lat", 32'(n), 32'd66);
    chk("tmo_busy_flag", 32'(out_tmo), 32'd1);
    chk("tmo_busy_prod", 32'(out_prod), 32'd0);
    $display("[TB] busy timeout: tmo %0d prod %h", out_tmo, out_prod);
    mode = 0;
    n = 0;
    while (busy_m && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) bound_fail("busy_release");
    chk("tmo_busy_still_valid", 32'(out_valid), 32'd1);
    take();

    // Busy never raised.
    mode = 2;
    push(vecs[1].mpd, vecs[1].mpr);
    wait_start(n);
    wait_valid(n);
    chk("tmo_arm_lat", 32'(n), 32'd5);
    chk("tmo_arm_flag", 32'(out_tmo), 32'd1);
    chk("tmo_arm_prod", 32'(out_prod), 32'd0);
    $display("[TB] arm timeout: tmo %0d prod %h", out_tmo, out_prod);
    take();
    mode = 0;

    // Reset while busy with two pairs queued.
    blen = 20;
    push(vecs[0].mpd, vecs[0].mpr);
    push(vecs[1].mpd, vecs[1].mpr);
    push(vecs[2].mpd, vecs[2].mpr);
    n = 0;
    while (!busy_m && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) bound_fail("busy_rise");
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen_valid = 1'b0;
    seen_start = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (out_valid) seen_valid = 1'b1;
      if (mult_start) seen_start = 1'b1;
    end
    chk("midrst_no_valid", 32'(seen_valid), 32'd0);
    chk("midrst_no_start", 32'(seen_start), 32'd0);
    chk("midrst_ready", 32'(in_ready), 32'd1);
    $display("[TB] mid-busy reset: valid seen %0d start seen %0d", seen_valid, seen_start);
    run_op(6);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
